// File: rtl/stream_capture_pkg.sv
// Shared definitions for the stream capture block: FSM encoding, burst-mode
// string constants and a width helper for counters and addresses.
// No logic; imported by stream_capture and its buffer.
package stream_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam string BURST_YES = "yes";
  localparam string BURST_NO  = "no";

  // ceil(log2(n)) but never below 1, so a one-entry buffer still gets an address bit
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_capture_buffer.sv
// Capture buffer: DEPTH x WIDTH RAM, one write port, one synchronous read port.
// Latency: raddr_i to rdata_o is 1 cycle; a same-edge write returns the old word.
// Backpressure: none, the write enable is the caller's handshake.
module stream_capture_buffer
  import stream_capture_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int WIDTH  = 22,
  parameter int ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array: written on an accepted word, never reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; non-blocking update gives read-before-write on a shared address
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_capture.sv
// Stream capture: after a start pulse accepts SIZE words, stores them, XOR-signs them.
// Latency: word to oCount/oSum 1 cycle, last word to oEnd 1 cycle, read port 1 cycle.
// Backpressure: oReady_AM is registered; high (or alternating) only while capturing.
module stream_capture
  import stream_capture_pkg::*;
#(
  parameter int    SIZE   = 3,
  parameter int    WIDTH  = 22,
  parameter string BURST  = "yes",
  localparam int   CNT_W  = clog2_min1(SIZE + 1),
  localparam int   ADDR_W = clog2_min1(SIZE)
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStart,
  input  logic              iValid_AM,
  output logic              oReady_AM,
  input  logic [WIDTH-1:0]  iData_AM,
  output logic              oEnd,
  output logic [CNT_W-1:0]  oCount,
  output logic [WIDTH-1:0]  oSum,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [WIDTH-1:0]  oRdData
);

  // Anything other than "no" is treated as burst mode
  localparam bit IS_BURST = (BURST != BURST_NO);

  state_e           state_q;
  logic             ready_q;
  logic             end_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] sum_q;

  logic accept;
  logic last_word;

  // ready_q is only ever set inside CAPTURE, so it alone qualifies the handshake
  assign accept    = (state_q == ST_CAPTURE) && iValid_AM && ready_q;
  assign last_word = (count_q == CNT_W'(SIZE - 1));

  // Run control: state, handshake ready, word count, signature and done flag
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      end_q   <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            state_q <= ST_CAPTURE;
            ready_q <= 1'b1;
            count_q <= '0;
            sum_q   <= '0;
          end
        end
        ST_CAPTURE: begin
          // iStart is deliberately ignored here so a run cannot be truncated
          if (accept) begin
            count_q <= count_q + CNT_W'(1);
            sum_q   <= sum_q ^ iData_AM;
          end
          if (accept && last_word) begin
            state_q <= ST_DONE;
            ready_q <= 1'b0;
            end_q   <= 1'b1;
          end else begin
            ready_q <= IS_BURST ? 1'b1 : ~ready_q;
          end
        end
        ST_DONE: begin
          if (iStart) begin
            state_q <= ST_CAPTURE;
            ready_q <= 1'b1;
            end_q   <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          end_q   <= 1'b0;
        end
      endcase
    end
  end

  stream_capture_buffer #(
    .DEPTH  (SIZE),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_buffer (
    .clk_i   (iCLK),
    .rst_ni  (iRST),
    .we_i    (accept),
    .waddr_i (ADDR_W'(count_q)),
    .wdata_i (iData_AM),
    .raddr_i (iRdAddr),
    .rdata_o (oRdData)
  );

  assign oReady_AM = ready_q;
  assign oEnd      = end_q;
  assign oCount    = count_q;
  assign oSum      = sum_q;

endmodule

// File: tb/tb_stream_capture.sv
// Bench for stream_capture: one burst instance and one alternating-ready instance
// share the stimulus; sel routes inputs to one and picks its outputs.
// Accepted words go to a scoreboard queue that the read-back pass drains.
module tb_stream_capture;

  localparam int SIZE  = 3;
  localparam int WIDTH = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             rst_n, start, valid, sel;
  logic [WIDTH-1:0] data;
  logic [1:0]       rdaddr;

  logic             ready_y, end_y, ready_n, end_n;
  logic [1:0]       count_y, count_n;
  logic [WIDTH-1:0] sum_y, sum_n, rd_y, rd_n;

  logic             ready, done;
  logic [1:0]       count;
  logic [WIDTH-1:0] sum, rddata;

  assign ready  = sel ? ready_n : ready_y;
  assign done   = sel ? end_n   : end_y;
  assign count  = sel ? count_n : count_y;
  assign sum    = sel ? sum_n   : sum_y;
  assign rddata = sel ? rd_n    : rd_y;

  stream_capture #(.SIZE(SIZE), .WIDTH(WIDTH), .BURST("yes")) dut_y (
    .iCLK(clk), .iRST(rst_n), .iStart(start & ~sel), .iValid_AM(valid & ~sel),
    .oReady_AM(ready_y), .iData_AM(data), .oEnd(end_y), .oCount(count_y),
    .oSum(sum_y), .iRdAddr(rdaddr), .oRdData(rd_y)
  );

  stream_capture #(.SIZE(SIZE), .WIDTH(WIDTH), .BURST("no")) dut_n (
    .iCLK(clk), .iRST(rst_n), .iStart(start & sel), .iValid_AM(valid & sel),
    .oReady_AM(ready_n), .iData_AM(data), .oEnd(end_n), .oCount(count_n),
    .oSum(sum_n), .iRdAddr(rdaddr), .oRdData(rd_n)
  );

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_sum;
  int               exp_cnt;
  int               entry_cyc;

  // Called at a negedge; returns at a negedge after the entry edge
  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    entry_cyc = cyc;
    exp_sum   = '0;
    exp_cnt   = 0;
    exp_q.delete();
  endtask

  // Offer one word and wait (bounded) for ready; the model follows only a real handshake
  task automatic send(input logic [WIDTH-1:0] w, output bit ok);
    valid = 1'b1;
    data  = w;
    ok    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      exp_q.push_back(w);
      exp_sum = exp_sum ^ w;
      exp_cnt++;
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; data = '0; rdaddr = '0; sel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({ready, done, count, sum, rddata} !== '0) begin bad++;
      $display("FAIL reset_outputs: got r=%b e=%b c=%0d s=%h rd=%h want all 0", ready, done, count, sum, rddata); end
    valid = 1'b1; data = 22'h155555;
    repeat (3) begin
      @(negedge clk);
      total++; if (ready !== 1'b0 || count !== 2'd0) begin bad++;
        $display("FAIL idle_no_ack: got ready=%b count=%0d want 0/0", ready, count); end
    end
    valid = 1'b0;
  endtask

  task automatic test_readback(input string nm);
    logic [WIDTH-1:0] w;
    for (int a = 0; a < SIZE; a++) begin
      rdaddr = 2'(a);
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL %s_scoreboard_empty: addr=%0d has no expected word", nm, a);
      end else begin
        w = exp_q.pop_front();
        total++; if (rddata !== w) begin bad++;
          $display("FAIL %s_read%0d: got %h want %h", nm, a, rddata, w); end
      end
    end
  endtask

  task automatic test_burst();
    logic [WIDTH-1:0] words [3] = '{22'h000001, 22'h000002, 22'h000004};
    bit ok;
    sel = 1'b0;
    start_pulse();
    total++; if (ready !== 1'b1) begin bad++;
      $display("FAIL burst_ready_first: got %b want 1", ready); end
    for (int i = 0; i < 3; i++) begin
      send(words[i], ok);
      total++; if (!ok || count !== 2'(exp_cnt) || sum !== exp_sum) begin bad++;
        $display("FAIL burst_word%0d: ok=%b count=%0d sum=%h want count=%0d sum=%h", i, ok, count, sum, exp_cnt, exp_sum); end
      if (i < 2) begin
        total++; if (done !== 1'b0 || ready !== 1'b1) begin bad++;
          $display("FAIL burst_mid%0d: got end=%b ready=%b want 0/1", i, done, ready); end
      end
    end
    total++; if (done !== 1'b1 || ready !== 1'b0 || cyc - entry_cyc != 3 || sum !== 22'h000007) begin bad++;
      $display("FAIL burst_done: end=%b ready=%b edges=%0d sum=%h want 1/0/3/000007", done, ready, cyc - entry_cyc, sum); end
    test_readback("burst");
  endtask

  task automatic test_overrun();
    valid = 1'b1;
    data  = 22'h3FFFFF;
    repeat (4) begin
      @(negedge clk);
      total++; if (ready !== 1'b0 || done !== 1'b1 || count !== 2'd3 || sum !== 22'h000007) begin bad++;
        $display("FAIL overrun: ready=%b end=%b count=%0d sum=%h want 0/1/3/000007", ready, done, count, sum); end
    end
    valid = 1'b0;
  endtask

  task automatic test_alternate();
    logic [WIDTH-1:0] words [3] = '{22'h000001, 22'h000002, 22'h000004};
    bit ok;
    logic last_ready;
    sel = 1'b1;
    @(negedge clk);
    start_pulse();
    total++; if (ready !== 1'b1) begin bad++;
      $display("FAIL alt_ready_first: got %b want 1", ready); end
    for (int i = 0; i < 3; i++) begin
      send(words[i], ok);
      total++; if (!ok || count !== 2'(exp_cnt) || sum !== exp_sum) begin bad++;
        $display("FAIL alt_word%0d: ok=%b count=%0d sum=%h want count=%0d sum=%h", i, ok, count, sum, exp_cnt, exp_sum); end
      if (i < 2) begin
        // ready toggles every edge, so right after an accept it must be low
        last_ready = ready;
        total++; if (last_ready !== 1'b0) begin bad++;
          $display("FAIL alt_gap%0d: got ready=%b want 0", i, last_ready); end
      end
    end
    // entry edge + 5 edges: words accepted on edges 1, 3, 5
    total++; if (done !== 1'b1 || cyc - entry_cyc != 5 || sum !== 22'h000007) begin bad++;
      $display("FAIL alt_done: end=%b edges=%0d sum=%h want 1/5/000007", done, cyc - entry_cyc, sum); end
    test_readback("alt");
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_gaps();
    logic [WIDTH-1:0] words [3] = '{22'h000111, 22'h000222, 22'h000333};
    bit ok;
    start_pulse();
    total++; if (count !== 2'd0 || done !== 1'b0) begin bad++;
      $display("FAIL gaps_start: count=%0d end=%b want 0/0", count, done); end
    for (int i = 0; i < 3; i++) begin
      send(words[i], ok);
      total++; if (!ok || count !== 2'(exp_cnt) || sum !== exp_sum) begin bad++;
        $display("FAIL gaps_word%0d: ok=%b count=%0d sum=%h want count=%0d sum=%h", i, ok, count, sum, exp_cnt, exp_sum); end
      repeat (2) begin
        @(negedge clk);
        total++; if (count !== 2'(exp_cnt)) begin bad++;
          $display("FAIL gaps_hold%0d: count=%0d want %0d", i, count, exp_cnt); end
      end
    end
    test_readback("gaps");
  endtask

  task automatic test_restart();
    bit ok;
    total++; if (done !== 1'b1) begin bad++;
      $display("FAIL restart_pre: end=%b want 1", done); end
    start_pulse();
    total++; if (done !== 1'b0 || count !== 2'd0 || sum !== '0 || ready !== 1'b1) begin bad++;
      $display("FAIL restart_entry: end=%b count=%0d sum=%h ready=%b want 0/0/0/1", done, count, sum, ready); end
    send(22'h00000A, ok);
    // start during CAPTURE must not clear anything
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    total++; if (count !== 2'd1 || sum !== 22'h00000A) begin bad++;
      $display("FAIL restart_ignored: count=%0d sum=%h want 1/00000a", count, sum); end
    send(22'h00000B, ok);
    send(22'h00000C, ok);
    total++; if (!ok || done !== 1'b1 || count !== 2'd3 || sum !== 22'h00000D || exp_sum !== 22'h00000D) begin bad++;
      $display("FAIL restart_done: end=%b count=%0d sum=%h want 1/3/00000d", done, count, sum); end
    test_readback("restart");
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] words [3] = '{22'h2AAAAA, 22'h0F0F0F, 22'h000100};
    bit ok;
    start_pulse();
    send(22'h000005, ok);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({ready_y, end_y, count_y, sum_y, rd_y} !== '0) begin bad++;
      $display("FAIL async_reset: r=%b e=%b c=%0d s=%h rd=%h want all 0", ready_y, end_y, count_y, sum_y, rd_y); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (done !== 1'b0 || count !== 2'd0) begin bad++;
      $display("FAIL post_reset: end=%b count=%0d want 0/0", done, count); end
    start_pulse();
    for (int i = 0; i < 3; i++) begin
      send(words[i], ok);
      if (i < 2) begin
        total++; if (done !== 1'b0) begin bad++;
          $display("FAIL rerun_early_end%0d: end=%b want 0", i, done); end
      end
    end
    total++; if (!ok || done !== 1'b1 || count !== 2'd3 || sum !== exp_sum) begin bad++;
      $display("FAIL rerun_done: end=%b count=%0d sum=%h want 1/3/%h", done, count, sum, exp_sum); end
    test_readback("rerun");
  endtask

  initial begin
    test_reset();
    test_burst();
    test_overrun();
    test_alternate();
    test_gaps();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
